riffa_tx_pipe_arbiter: RTL and testbench

- Shares one RIFFA TX channel between NUM_REQ AHIR output pipes.
- Each requester posts a transfer request with a word length. The arbiter grants round-robin, drives the RIFFA TX handshake for the granted requester, and moves that pipe's data onto CHNL_TX_DATA until the length is exhausted.
- Sits between the AHIR system's output pipes and the RIFFA channel TX side.
- Replaces the fixed-length, single-pipe TX sequencing used today.

---
 rtl/riffa_ahir_pkg.sv | 18 +
 rtl/rr_arbiter.sv | 31 +++
 rtl/riffa_tx_pipe_arbiter.sv | 134 +++++++++++++
 tb/tb_riffa_tx_pipe_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riffa_ahir_pkg.sv
// Shared types and constants for the RIFFA <-> AHIR pipe bridge.
// Used by the TX arbiter today and the RX demux later.
package riffa_ahir_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic        TX_LAST = 1'b1;
  localparam logic [30:0] TX_OFF  = '0;

  function automatic int num_words(input int width);
    return width / 32;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set req bit after i_ptr.
// Returns one-hot select, its index and an any-request flag.
module rr_arbiter #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_sel,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);

  logic [IW-1:0] w_j;

  always_comb begin
    o_sel = '0;
    o_idx = '0;
    o_any = 1'b0;
    w_j   = '0;
    for (int k = 1; k <= N; k++) begin
      w_j = IW'((int'(i_ptr) + k) % N);
      if (!o_any && i_req[w_j]) begin
        o_any      = 1'b1;
        o_sel[w_j] = 1'b1;
        o_idx      = w_j;
      end
    end
  end

endmodule

// File: rtl/riffa_tx_pipe_arbiter.sv
// Shares one RIFFA TX channel between NUM_REQ AHIR output pipes,
// granting round-robin and streaming the winner's pipe for tLen words.
module riffa_tx_pipe_arbiter
  import riffa_ahir_pkg::*;
#(
  parameter int C_PCI_DATA_WIDTH = 32,
  parameter int NUM_REQ          = 2
) (
  input  logic                                CLK,
  input  logic                                RST_N,
  input  logic [NUM_REQ-1:0]                  req,
  input  logic [32*NUM_REQ-1:0]               req_len,
  output logic [NUM_REQ-1:0]                  grant,
  output logic [NUM_REQ-1:0]                  done,
  input  logic [C_PCI_DATA_WIDTH*NUM_REQ-1:0] pipe_read_data,
  output logic [NUM_REQ-1:0]                  pipe_read_req,
  input  logic [NUM_REQ-1:0]                  pipe_read_ack,
  output logic                                CHNL_TX,
  input  logic                                CHNL_TX_ACK,
  output logic                                CHNL_TX_LAST,
  output logic [31:0]                         CHNL_TX_LEN,
  output logic [30:0]                         CHNL_TX_OFF,
  output logic [C_PCI_DATA_WIDTH-1:0]         CHNL_TX_DATA,
  output logic                                CHNL_TX_DATA_VALID,
  input  logic                                CHNL_TX_DATA_REN
);

  localparam int NUM_WORDS = num_words(C_PCI_DATA_WIDTH);
  localparam int IW        = $clog2(NUM_REQ);
  localparam int W         = C_PCI_DATA_WIDTH;

  state_t              r_state, w_state_nxt;
  logic [NUM_REQ-1:0]  r_grant, w_grant_nxt;
  logic [NUM_REQ-1:0]  r_done, w_done_nxt;
  logic [IW-1:0]       r_gidx, w_gidx_nxt;
  logic [IW-1:0]       r_ptr, w_ptr_nxt;
  logic [31:0]         r_tlen, w_tlen_nxt;
  logic [31:0]         r_tcount, w_tcount_nxt;

  logic [NUM_REQ-1:0]  w_sel;
  logic [IW-1:0]       w_idx;
  logic                w_any;
  logic [31:0]         w_len_arr [NUM_REQ];
  logic [W-1:0]        w_data_arr [NUM_REQ];
  logic                w_send;
  logic                w_more;
  logic                w_valid;
  logic                w_beat;
  logic                w_unused_ack;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
    assign w_len_arr[i]  = req_len[32*i +: 32];
    assign w_data_arr[i] = pipe_read_data[W*i +: W];
  end

  rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_rr (
    .i_req (req),
    .i_ptr (r_ptr),
    .o_sel (w_sel),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  assign w_send  = (r_state == ST_SEND);
  assign w_more  = (r_tcount < r_tlen);
  assign w_valid = w_send & pipe_read_ack[r_gidx] & w_more;
  assign w_beat  = w_valid & CHNL_TX_DATA_REN;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state  <= ST_IDLE;
      r_grant  <= '0;
      r_done   <= '0;
      r_gidx   <= '0;
      r_ptr    <= IW'(NUM_REQ - 1);
      r_tlen   <= '0;
      r_tcount <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_grant  <= w_grant_nxt;
      r_done   <= w_done_nxt;
      r_gidx   <= w_gidx_nxt;
      r_ptr    <= w_ptr_nxt;
      r_tlen   <= w_tlen_nxt;
      r_tcount <= w_tcount_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_grant_nxt  = r_grant;
    w_done_nxt   = '0;
    w_gidx_nxt   = r_gidx;
    w_ptr_nxt    = r_ptr;
    w_tlen_nxt   = r_tlen;
    w_tcount_nxt = r_tcount;
    unique case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_grant_nxt  = w_sel;
          w_gidx_nxt   = w_idx;
          w_tlen_nxt   = w_len_arr[w_idx];
          w_tcount_nxt = '0;
          w_state_nxt  = (w_len_arr[w_idx] != '0) ? ST_SEND : ST_DONE;
        end
      end
      ST_SEND: begin
        // >= so a padded final beat overshooting tLen still terminates
        if (w_beat) w_tcount_nxt = r_tcount + 32'(NUM_WORDS);
        else if (!w_more) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
        w_done_nxt  = r_grant;
        w_ptr_nxt   = r_gidx;
        w_grant_nxt = '0;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign grant              = r_grant;
  assign done               = r_done;
  assign CHNL_TX            = w_send;
  assign CHNL_TX_LAST       = TX_LAST;
  assign CHNL_TX_OFF        = TX_OFF;
  assign CHNL_TX_LEN        = w_send ? r_tlen : '0;
  assign CHNL_TX_DATA       = w_send ? w_data_arr[r_gidx] : '0;
  assign CHNL_TX_DATA_VALID = w_valid;
  assign pipe_read_req      = (w_send & CHNL_TX_DATA_REN & w_more) ? r_grant : '0;
  // RIFFA accept is informational only; REN already gates the data
  assign w_unused_ack       = CHNL_TX_ACK;

endmodule

// File: tb/tb_riffa_tx_pipe_arbiter.sv
// Randomized bench for riffa_tx_pipe_arbiter with a transaction-level
// reference model and directed literal checks.
module tb_riffa_tx_pipe_arbiter;

  localparam int W  = 64;
  localparam int N  = 4;
  localparam int NW = W / 32;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req;
  logic [32*N-1:0] req_len;
  logic [N-1:0]   grant, done;
  logic [W*N-1:0] pipe_read_data;
  logic [N-1:0]   pipe_read_req;
  logic [N-1:0]   pipe_read_ack;
  logic           tx, tx_ack, tx_last;
  logic [31:0]    tx_len;
  logic [30:0]    tx_off;
  logic [W-1:0]   tx_data;
  logic           tx_valid, ren;

  int n_tests = 0;
  int n_fail  = 0;
  int ren_mode = 0;
  int ack_mode = 0;
  bit ren_tog  = 1'b0;

  // model state
  int     m_phase, m_owner, m_last, m_done, m_nd;
  longint m_sent, m_len;

  // DUT observations
  int dut_beats = 0;
  int done_q[$];
  int b0;

  riffa_tx_pipe_arbiter #(.C_PCI_DATA_WIDTH(W), .NUM_REQ(N)) dut (
    .CLK                (clk),
    .RST_N              (rst_n),
    .req                (req),
    .req_len            (req_len),
    .grant              (grant),
    .done               (done),
    .pipe_read_data     (pipe_read_data),
    .pipe_read_req      (pipe_read_req),
    .pipe_read_ack      (pipe_read_ack),
    .CHNL_TX            (tx),
    .CHNL_TX_ACK        (tx_ack),
    .CHNL_TX_LAST       (tx_last),
    .CHNL_TX_LEN        (tx_len),
    .CHNL_TX_OFF        (tx_off),
    .CHNL_TX_DATA       (tx_data),
    .CHNL_TX_DATA_VALID (tx_valid),
    .CHNL_TX_DATA_REN   (ren)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // input driver: pipe data, acks, REN
  initial begin
    pipe_read_data = '0;
    pipe_read_ack  = '1;
    ren            = 1'b1;
    tx_ack         = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 2 * N; i++)
        pipe_read_data[32*i +: 32] = $urandom;
      pipe_read_ack = (ack_mode == 0) ? '1 : N'($urandom);
      ren_tog = ~ren_tog;
      case (ren_mode)
        0: ren = 1'b1;
        1: ren = ren_tog;
        default: ren = 1'($urandom);
      endcase
      tx_ack = 1'($urandom);
    end
  end

  // reference model: one transfer at a time, round-robin from last winner
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0;
      m_owner = 0;
      m_last  = N - 1;
      m_done  = -1;
      m_sent  = 0;
      m_len   = 0;
    end else begin
      m_nd = -1;
      case (m_phase)
        0: begin
          for (int k = 1; k <= N; k++) begin
            if (m_phase == 0 && req[(m_last + k) % N]) begin
              m_owner = (m_last + k) % N;
              m_len   = longint'(req_len[32*m_owner +: 32]);
              m_sent  = 0;
              m_phase = (m_len != 0) ? 1 : 2;
            end
          end
        end
        1: begin
          if (pipe_read_ack[m_owner] && m_sent < m_len && ren)
            m_sent += NW;
          else if (m_sent >= m_len)
            m_phase = 2;
        end
        default: begin
          m_nd    = m_owner;
          m_last  = m_owner;
          m_phase = 0;
        end
      endcase
      m_done = m_nd;
    end
  end

  // compare process plus DUT observation log
  always @(negedge clk) begin
    logic [N-1:0] eg, ed, er;
    logic         ev;
    if (rst_n) begin
      eg = (m_phase != 0) ? N'(1 << m_owner) : '0;
      ed = (m_done >= 0) ? N'(1 << m_done) : '0;
      ev = (m_phase == 1) && pipe_read_ack[m_owner] && (m_sent < m_len);
      er = ((m_phase == 1) && ren && (m_sent < m_len)) ? eg : '0;
      chk("grant", 64'(grant), 64'(eg));
      chk("done", 64'(done), 64'(ed));
      chk("chnl_tx", 64'(tx), 64'(m_phase == 1));
      chk("tx_len", 64'(tx_len), (m_phase == 1) ? 64'(m_len) : 64'd0);
      chk("valid", 64'(tx_valid), 64'(ev));
      chk("read_req", 64'(pipe_read_req), 64'(er));
      chk("tx_last", 64'(tx_last), 64'd1);
      chk("tx_off", 64'(tx_off), 64'd0);
      if (ev) chk("tx_data", tx_data, pipe_read_data[W*m_owner +: W]);
      if (tx_valid && ren) dut_beats++;
      for (int i = 0; i < N; i++) if (done[i]) done_q.push_back(i);
    end
  end

  task automatic wait_done(input int n, input int max);
    for (int c = 0; c < max && done_q.size() < n; c++) tick();
    chk("wait_done", 64'(done_q.size()), 64'(n));
  endtask

  task automatic settle();
    req = '0;
    repeat (20) tick();
    done_q.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n   = 1'b0;
    req     = '0;
    req_len = '0;
    repeat (3) tick();
    chk("rst_grant", 64'(grant), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_tx", 64'(tx), 64'd0);
    chk("rst_valid", 64'(tx_valid), 64'd0);
    chk("rst_rreq", 64'(pipe_read_req), 64'd0);
    chk("rst_len", 64'(tx_len), 64'd0);
    chk("rst_data", tx_data, 64'd0);
    rst_n = 1'b1;

    // single request, len 4 -> 2 beats of 64 bits
    b0 = dut_beats;
    req = 4'b0001;
    req_len[31:0] = 32'd4;
    tick();
    chk("a_grant", 64'(grant), 64'b0001);
    chk("a_tx", 64'(tx), 64'd1);
    chk("a_len", 64'(tx_len), 64'd4);
    req = '0;
    wait_done(1, 40);
    chk("a_beats", 64'(dut_beats - b0), 64'd2);
    if (done_q.size() > 0) chk("a_done_idx", 64'(done_q[0]), 64'd0);
    settle();

    // round robin after reset: 0,1,0,1
    do_reset();
    req = 4'b0011;
    req_len[31:0]  = 32'd2;
    req_len[63:32] = 32'd2;
    wait_done(4, 100);
    req = '0;
    for (int i = 0; i < 4; i++)
      if (done_q.size() > i) chk("rr_order", 64'(done_q[i]), 64'(i % 2));
    settle();

    // backpressure, len 5 -> 3 padded beats
    ren_mode = 1;
    ack_mode = 1;
    b0 = dut_beats;
    req = 4'b0001;
    req_len[31:0] = 32'd5;
    tick();
    req = '0;
    wait_done(1, 300);
    chk("bp_beats", 64'(dut_beats - b0), 64'd3);
    ren_mode = 0;
    ack_mode = 0;
    settle();

    // zero length: done two cycles after req, no CHNL_TX
    b0 = dut_beats;
    req = 4'b0010;
    req_len[63:32] = 32'd0;
    tick();
    chk("z_grant", 64'(grant), 64'b0010);
    chk("z_tx", 64'(tx), 64'd0);
    req = '0;
    tick();
    chk("z_done", 64'(done), 64'b0010);
    chk("z_tx2", 64'(tx), 64'd0);
    tick();
    chk("z_beats", 64'(dut_beats - b0), 64'd0);
    settle();

    // reset mid-send after 2 of 8 beats
    b0 = dut_beats;
    req = 4'b0001;
    req_len[31:0] = 32'd16;
    for (int c = 0; c < 50 && (dut_beats - b0) < 2; c++) @(negedge clk);
    chk("mr_beats", 64'(dut_beats - b0), 64'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr_grant", 64'(grant), 64'd0);
    chk("mr_tx", 64'(tx), 64'd0);
    chk("mr_valid", 64'(tx_valid), 64'd0);
    chk("mr_rreq", 64'(pipe_read_req), 64'd0);
    chk("mr_data", tx_data, 64'd0);
    chk("mr_done", 64'(done), 64'd0);
    done_q.delete();
    req = 4'b0011;
    req_len[31:0]  = 32'd2;
    req_len[63:32] = 32'd2;
    tick();
    rst_n = 1'b1;
    tick();
    chk("mr_first", 64'(grant), 64'b0001);
    wait_done(1, 40);
    req = '0;
    if (done_q.size() > 0) chk("mr_done_idx", 64'(done_q[0]), 64'd0);
    settle();

    // four requesters: after requester 1, req=1010 -> 3 then 1
    req = 4'b0010;
    req_len[63:32]  = 32'd2;
    req_len[127:96] = 32'd2;
    tick();
    chk("n4_first", 64'(grant), 64'b0010);
    req = 4'b1010;
    wait_done(3, 100);
    req = '0;
    for (int i = 0; i < 3; i++)
      if (done_q.size() > i)
        chk("n4_order", 64'(done_q[i]), (i == 1) ? 64'd3 : 64'd1);
    settle();

    // random traffic against the model
    ren_mode = 2;
    ack_mode = 1;
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(3) == 0) begin
        req = N'($urandom);
        for (int i = 0; i < N; i++)
          req_len[32*i +: 32] = 32'($urandom_range(7));
      end
      tick();
    end
    req = '0;
    repeat (80) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
